nf10_barrier_client: RTL and testbench

Per-port barrier requester: the client end of the barrier handshake. Sits inside each stimulus/record port model and transaction logger. Accepts a barrier command from the local sequencer, waits until local traffic has drained and gone quiet, then raises `barrier_req` toward the barrier controller. After the controller's `barrier_proceed` has been seen high and then low, it signals the sequencer to continue. It also generates the `activity` indication the controller uses to extend its inactivity timeout.

---
 rtl/nf10_barrier_client.sv | 147 ++++++++++++++
 tb/tb_nf10_barrier_client.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_barrier_client.sv
// Client end of the barrier handshake: drains local traffic, waits for
// quiet, requests the barrier and reports completion to the sequencer.
module nf10_barrier_client #(
    parameter int CNT_WIDTH      = 16,
    parameter int QUIET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1500
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    input  logic                 barrier_valid,
    output logic                 barrier_ready,
    input  logic                 pkt_issue,
    input  logic                 pkt_retire,
    input  logic                 barrier_proceed,
    output logic                 barrier_req,
    output logic                 activity,
    output logic                 barrier_done,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic                 err_underflow,
    output logic                 err_overflow,
    output logic                 err_traffic,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REQ,
        RELEASE
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
    localparam logic [7:0]           QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam logic [15:0]          TMO        = 16'(TIMEOUT_CYCLES);

    state_e                 state_q, state_d;
    logic                   sync1_q, proceed_s;
    logic [7:0]             quiet_q, quiet_d;
    logic [15:0]            req_cnt_q, req_cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   req_q, done_q, done_d, act_q;
    logic                   unf_q, unf_d, ovf_q, ovf_d;
    logic                   trf_q, trf_d, tmo_q, tmo_d;
    logic                   ready;
    logic                   qualify;

    assign qualify = (cnt_q == '0) && !pkt_issue && !pkt_retire;

    always_comb begin
        cnt_d = cnt_q;
        unf_d = unf_q;
        ovf_d = ovf_q;
        trf_d = trf_q;
        if (pkt_issue && !pkt_retire) begin
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + CNT_ONE;
        end else if (pkt_retire && !pkt_issue) begin
            if (cnt_q == '0) unf_d = 1'b1;
            else             cnt_d = cnt_q - CNT_ONE;
        end
        // Traffic while the barrier is requested breaks the quiet guarantee.
        if (state_q == REQ && (pkt_issue || pkt_retire)) trf_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        quiet_d   = quiet_q;
        req_cnt_d = req_cnt_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (barrier_valid) begin
                    state_d = DRAIN;
                    quiet_d = '0;
                end
            end
            DRAIN: begin
                if (!qualify) begin
                    quiet_d = '0;
                end else if (quiet_q == QUIET_LAST) begin
                    state_d   = REQ;
                    req_cnt_d = '0;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            REQ: begin
                if (req_cnt_q != '1) req_cnt_d = req_cnt_q + 16'd1;
                if (req_cnt_d == TMO) tmo_d = 1'b1;
                if (proceed_s) state_d = RELEASE;
            end
            RELEASE: begin
                if (!proceed_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            proceed_s <= 1'b0;
            quiet_q   <= '0;
            req_cnt_q <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            act_q     <= 1'b0;
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            trf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= barrier_proceed;
            proceed_s <= sync1_q;
            quiet_q   <= quiet_d;
            req_cnt_q <= req_cnt_d;
            cnt_q     <= cnt_d;
            req_q     <= (state_d == REQ);
            done_q    <= done_d;
            act_q     <= pkt_issue | pkt_retire;
            unf_q     <= unf_d;
            ovf_q     <= ovf_d;
            trf_q     <= trf_d;
            tmo_q     <= tmo_d;
        end
    end

    assign barrier_ready = ready;
    assign barrier_req   = req_q;
    assign barrier_done  = done_q;
    assign activity      = act_q;
    assign outstanding   = cnt_q;
    assign err_underflow = unf_q;
    assign err_overflow  = ovf_q;
    assign err_traffic   = trf_q;
    assign err_timeout   = tmo_q;

endmodule

// File: tb/tb_nf10_barrier_client.sv
// Bench for nf10_barrier_client: scenario tasks plus a scoreboard of
// expected barrier_done cycles.
module tb_nf10_barrier_client;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, issue = 1'b0, retire = 1'b0, proceed = 1'b0;
    logic        ready, req, act, done;
    logic [15:0] outs;
    logic        e_unf, e_ovf, e_trf, e_tmo;

    logic        issue2 = 1'b0, retire2 = 1'b0;
    logic        ready2, req2, act2, done2;
    logic [3:0]  outs2;
    logic        e_unf2, e_ovf2, e_trf2, e_tmo2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nf10_barrier_client #(
        .CNT_WIDTH(16), .QUIET_CYCLES(4), .TIMEOUT_CYCLES(1500)
    ) dut (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .barrier_valid(valid), .barrier_ready(ready),
        .pkt_issue(issue), .pkt_retire(retire),
        .barrier_proceed(proceed), .barrier_req(req),
        .activity(act), .barrier_done(done), .outstanding(outs),
        .err_underflow(e_unf), .err_overflow(e_ovf),
        .err_traffic(e_trf), .err_timeout(e_tmo)
    );

    nf10_barrier_client #(
        .CNT_WIDTH(4), .QUIET_CYCLES(4), .TIMEOUT_CYCLES(1500)
    ) dut2 (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .barrier_valid(1'b0), .barrier_ready(ready2),
        .pkt_issue(issue2), .pkt_retire(retire2),
        .barrier_proceed(1'b0), .barrier_req(req2),
        .activity(act2), .barrier_done(done2), .outstanding(outs2),
        .err_underflow(e_unf2), .err_overflow(e_ovf2),
        .err_traffic(e_trf2), .err_timeout(e_tmo2)
    );

    // Scoreboard: every barrier_done cycle must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_done unexpected pulse at cycle %0d", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL sb_done cycle got %0d expected %0d", cyc, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic pulse_issue(input int n);
        for (int i = 0; i < n; i++) begin
            issue = 1'b1;
            step(1);
            issue = 1'b0;
        end
    endtask

    task automatic accept_and_req();
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        chk("accept_ready_low", 32'(ready), 32'd0);
        step(3);
        chk("req_low_before_quiet", 32'(req), 32'd0);
        step(1);
        chk("req_high_after_quiet", 32'(req), 32'd1);
    endtask

    task automatic do_release();
        proceed = 1'b1;
        step(2);
        chk("req_held_2_edges", 32'(req), 32'd1);
        step(1);
        chk("req_fall_3_edges", 32'(req), 32'd0);
        step(1);
        proceed = 1'b0;
        exp_q.push_back(cyc + 3);
        step(2);
        chk("done_not_early", 32'(done), 32'd0);
        step(1);
        chk("done_high", 32'(done), 32'd1);
        chk("ready_in_done", 32'(ready), 32'd1);
        step(1);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_act", 32'(act), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_errs", {28'd0, e_unf, e_ovf, e_trf, e_tmo}, 32'd0);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        accept_and_req();
        do_release();
    endtask

    task automatic test_drain();
        pulse_issue(3);
        chk("drain_outs3", 32'(outs), 32'd3);
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            step(4);
            chk("drain_req_low_busy", 32'(req), 32'd0);
            retire = 1'b1;
            step(1);
            retire = 1'b0;
        end
        chk("drain_outs0", 32'(outs), 32'd0);
        step(2);
        issue = 1'b1;
        retire = 1'b1;
        step(1);
        issue = 1'b0;
        retire = 1'b0;
        step(3);
        chk("drain_restart_low", 32'(req), 32'd0);
        step(1);
        chk("drain_restart_high", 32'(req), 32'd1);
        chk("drain_no_unf", 32'(e_unf), 32'd0);
        do_release();
    endtask

    task automatic test_counter();
        pulse_issue(5);
        issue = 1'b1;
        retire = 1'b1;
        step(1);
        issue = 1'b0;
        retire = 1'b0;
        chk("cnt_both_hold", 32'(outs), 32'd5);
        chk("cnt_activity", 32'(act), 32'd1);
        step(1);
        chk("cnt_activity_clr", 32'(act), 32'd0);
        for (int i = 0; i < 6; i++) begin
            retire = 1'b1;
            step(1);
            retire = 1'b0;
        end
        chk("cnt_unf_zero", 32'(outs), 32'd0);
        chk("cnt_unf_flag", 32'(e_unf), 32'd1);
        for (int i = 0; i < 15; i++) begin
            issue2 = 1'b1;
            step(1);
            issue2 = 1'b0;
        end
        chk("cnt_full_no_ovf", {27'd0, e_ovf2, outs2}, 32'h0f);
        issue2 = 1'b1;
        step(1);
        issue2 = 1'b0;
        chk("cnt_ovf_sat", 32'(outs2), 32'd15);
        chk("cnt_ovf_flag", 32'(e_ovf2), 32'd1);
    endtask

    task automatic test_timeout();
        accept_and_req();
        step(1400);
        chk("tmo_not_early", 32'(e_tmo), 32'd0);
        step(150);
        chk("tmo_flag", 32'(e_tmo), 32'd1);
        chk("tmo_req_held", 32'(req), 32'd1);
        chk("trf_clear", 32'(e_trf), 32'd0);
        pulse_issue(1);
        chk("trf_flag", 32'(e_trf), 32'd1);
        chk("trf_outs", 32'(outs), 32'd1);
        retire = 1'b1;
        step(1);
        retire = 1'b0;
        chk("trf_outs0", 32'(outs), 32'd0);
        do_release();
    endtask

    task automatic test_reset_mid();
        accept_and_req();
        step(3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_errs", {28'd0, e_unf, e_ovf, e_trf, e_tmo}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_back_to_back();
        accept_and_req();
        proceed = 1'b1;
        step(4);
        chk("b2b_req_low", 32'(req), 32'd0);
        proceed = 1'b0;
        exp_q.push_back(cyc + 3);
        step(3);
        chk("b2b_done_ready", {30'd0, done, ready}, 32'd3);
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        chk("b2b_accepted", 32'(ready), 32'd0);
        step(3);
        chk("b2b_req_low2", 32'(req), 32'd0);
        step(1);
        chk("b2b_req_high2", 32'(req), 32'd1);
        do_release();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_counter();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        step(5);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
